// File: rtl/fsm_supervisor_pkg.sv
// Shared types and default constants for the worker-FSM supervisor.
package fsm_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_KILL    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_REPORT  = 3'd5
  } state_t;

  localparam int unsigned TIMEOUT_DEF   = 128;
  localparam int unsigned KILL_HOLD_DEF = 4;
  localparam int unsigned MAX_RETRY_DEF = 2;

  localparam int unsigned WDOG_W  = 10;
  localparam int unsigned TRIES_W = 3;

  // RECOVER spans kill release plus one idle-settle cycle
  localparam logic [WDOG_W-1:0] RECOVER_LAST = 10'd1;

endpackage

// File: rtl/fsm_supervisor_timer.sv
// Shared up-counter for watchdog, kill hold and recover spacing;
// cleared on every state change, flags when the count reaches 'last'.
module sup_timer
  import fsm_supervisor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [WDOG_W-1:0] last,
  output logic              hit
);

  logic [WDOG_W-1:0] cnt_r;

  // Counter register; saturates so idle states can never wrap it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r != {WDOG_W{1'b1}}) begin
      cnt_r <= cnt_r + 10'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == last);

endmodule

// File: rtl/fsm_supervisor.sv
// Supervises a worker FSM: launches jobs, enforces a watchdog, kills and
// retries on timeout, and reports the outcome to the host.
module fsm_supervisor
  import fsm_supervisor_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned KILL_HOLD = KILL_HOLD_DEF,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               abort,
  output logic               go,
  output logic               kill,
  input  logic               done,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_ok,
  output logic [TRIES_W-1:0] resp_tries,
  output logic               err_spurious
);

  localparam logic [WDOG_W-1:0]  WAIT_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0]  KILL_LAST = WDOG_W'(KILL_HOLD - 1);
  localparam logic [TRIES_W-1:0] TRY_LIMIT = TRIES_W'(MAX_RETRY + 1);

  state_t             state_r, state_s;
  logic [TRIES_W-1:0] tries_r, tries_s;
  logic               abort_r, abort_s;
  logic               resp_ok_r, resp_ok_s;
  logic [TRIES_W-1:0] resp_tries_r, resp_tries_s;
  logic               go_r, kill_r, resp_valid_r, err_spurious_r;
  logic               tmr_clr_s, tmr_hit_s;
  logic [WDOG_W-1:0]  tmr_last_s;

  sup_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr_s),
    .last  (tmr_last_s),
    .hit   (tmr_hit_s)
  );

  // Next-state, job bookkeeping and timer terminal-count selection
  always_comb begin
    state_s      = state_r;
    tries_s      = tries_r;
    abort_s      = abort_r;
    resp_ok_s    = resp_ok_r;
    resp_tries_s = resp_tries_r;
    tmr_last_s   = {WDOG_W{1'b1}};
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          tries_s = '0;
          abort_s = 1'b0;
          state_s = ST_LAUNCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        tries_s = tries_r + TRIES_W'(1);
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_last_s = WAIT_LAST;
        // done outranks a coincident abort or timeout
        if (done) begin
          resp_ok_s    = 1'b1;
          resp_tries_s = tries_r;
          state_s      = ST_REPORT;
        end else if (abort) begin
          abort_s = 1'b1;
          state_s = ST_KILL;
        end else if (tmr_hit_s) begin
          state_s = ST_KILL;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_KILL: begin
        tmr_last_s = KILL_LAST;
        if (tmr_hit_s) begin
          state_s = ST_RECOVER;
        end else begin
          state_s = ST_KILL;
        end
      end
      ST_RECOVER: begin
        tmr_last_s = RECOVER_LAST;
        if (tmr_hit_s && (abort_r || (tries_r == TRY_LIMIT))) begin
          resp_ok_s    = 1'b0;
          resp_tries_s = tries_r;
          state_s      = ST_REPORT;
        end else if (tmr_hit_s) begin
          state_s = ST_LAUNCH;
        end else begin
          state_s = ST_RECOVER;
        end
      end
      ST_REPORT: begin
        if (resp_ready) begin
          resp_ok_s    = 1'b0;
          resp_tries_s = '0;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    tmr_clr_s = (state_s != state_r);
  end

  // State, job context and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      tries_r        <= '0;
      abort_r        <= 1'b0;
      resp_ok_r      <= 1'b0;
      resp_tries_r   <= '0;
      go_r           <= 1'b0;
      kill_r         <= 1'b0;
      resp_valid_r   <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      tries_r        <= tries_s;
      abort_r        <= abort_s;
      resp_ok_r      <= resp_ok_s;
      resp_tries_r   <= resp_tries_s;
      go_r           <= (state_s == ST_LAUNCH);
      kill_r         <= (state_s == ST_KILL);
      resp_valid_r   <= (state_s == ST_REPORT);
      err_spurious_r <= err_spurious_r | (done & (state_r != ST_WAIT));
    end
  end

  assign req_ready    = (state_r == ST_IDLE);
  assign go           = go_r;
  assign kill         = kill_r;
  assign resp_valid   = resp_valid_r;
  assign resp_ok      = resp_ok_r;
  assign resp_tries   = resp_tries_r;
  assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_fsm_supervisor.sv
// Scoreboard bench for fsm_supervisor with a behavioural worker FSM model.
module tb_fsm_supervisor;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, abort, resp_ready;
  logic       req_ready, go, kill, resp_valid, resp_ok, err_spurious, done;
  logic [2:0] resp_tries;

  logic       worker_en, worker_done, stray_done;
  int         worker_delay;
  int         wk_cnt = 0;

  int         n_vec = 0;
  int         n_err = 0;

  // monitor-owned history
  int         cyc = 0;
  int         go_cyc[$];
  int         kill_cyc[$];
  int         kill_len[$];
  int         kill_run = 0;
  logic       obs_ok[$];
  logic [2:0] obs_tries[$];
  logic       overlap = 1'b0;

  // bench-owned scoreboard
  logic       exp_ok[$];
  logic [2:0] exp_tries[$];
  int         obs_idx = 0;

  assign done = worker_done | stray_done;

  always #5 clk = ~clk;

  fsm_supervisor #(.TIMEOUT(128), .KILL_HOLD(4), .MAX_RETRY(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .abort        (abort),
    .go           (go),
    .kill         (kill),
    .done         (done),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_ok      (resp_ok),
    .resp_tries   (resp_tries),
    .err_spurious (err_spurious)
  );

  // Worker model: done one cycle, worker_delay cycles after go; kill cancels
  always @(negedge clk) begin
    if (kill || !rst_n) begin
      wk_cnt <= 0;
      worker_done <= 1'b0;
    end else if (go && worker_en) begin
      wk_cnt <= worker_delay;
      worker_done <= 1'b0;
    end else if (wk_cnt > 0) begin
      wk_cnt <= wk_cnt - 1;
      worker_done <= (wk_cnt == 1);
    end else begin
      worker_done <= 1'b0;
    end
  end

  // Monitor: records go/kill timing and accepted responses
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (go) go_cyc.push_back(cyc);
    if (kill && kill_run == 0) kill_cyc.push_back(cyc);
    if (kill) kill_run <= kill_run + 1;
    else if (kill_run != 0) begin
      kill_len.push_back(kill_run);
      kill_run <= 0;
    end
    if (go && kill) overlap <= 1'b1;
    if (resp_valid && resp_ready) begin
      obs_ok.push_back(resp_ok);
      obs_tries.push_back(resp_tries);
    end
  end

  task automatic send_req();
    @(posedge clk); #1 req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (obs_ok.size() > obs_idx) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; resp_ready = 1'b1;
    stray_done = 1'b0; worker_en = 1'b0; worker_delay = 102;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({go, kill, resp_valid, resp_ok, resp_tries, err_spurious} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {go, kill, resp_valid, resp_ok, resp_tries, err_spurious});
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_success(input int delay, input string nm);
    bit seen; int g0, k0; logic e_ok; logic [2:0] e_tr;
    worker_en = 1'b1; worker_delay = delay;
    g0 = go_cyc.size(); k0 = kill_cyc.size();
    send_req();
    exp_ok.push_back(1'b1); exp_tries.push_back(3'd1);
    wait_resp(300, seen);
    e_ok = exp_ok.pop_front(); e_tr = exp_tries.pop_front();
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL %s_resp: no response, expected ok=%b tries=%0d", nm, e_ok, e_tr);
    end else begin
      if (obs_ok[obs_idx] !== e_ok || obs_tries[obs_idx] !== e_tr) begin
        n_err++;
        $display("FAIL %s_resp: got ok=%b tries=%0d expected ok=%b tries=%0d",
                 nm, obs_ok[obs_idx], obs_tries[obs_idx], e_ok, e_tr);
      end
      obs_idx++;
    end
    n_vec++;
    if (go_cyc.size() - g0 !== 1) begin
      n_err++; $display("FAIL %s_go_count: got %0d expected 1", nm, go_cyc.size() - g0);
    end
    n_vec++;
    if (kill_cyc.size() - k0 !== 0) begin
      n_err++; $display("FAIL %s_kill_count: got %0d expected 0", nm, kill_cyc.size() - k0);
    end
  endtask

  task automatic test_timeout();
    bit seen; int g0, k0, l0; logic e_ok; logic [2:0] e_tr;
    worker_en = 1'b0;
    g0 = go_cyc.size(); k0 = kill_cyc.size(); l0 = kill_len.size();
    send_req();
    exp_ok.push_back(1'b0); exp_tries.push_back(3'd3);
    wait_resp(700, seen);
    e_ok = exp_ok.pop_front(); e_tr = exp_tries.pop_front();
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL timeout_resp: no response, expected ok=%b tries=%0d", e_ok, e_tr);
    end else begin
      if (obs_ok[obs_idx] !== e_ok || obs_tries[obs_idx] !== e_tr) begin
        n_err++;
        $display("FAIL timeout_resp: got ok=%b tries=%0d expected ok=%b tries=%0d",
                 obs_ok[obs_idx], obs_tries[obs_idx], e_ok, e_tr);
      end
      obs_idx++;
    end
    n_vec++;
    if (go_cyc.size() - g0 !== 3 || kill_cyc.size() - k0 !== 3 || kill_len.size() - l0 !== 3) begin
      n_err++;
      $display("FAIL timeout_counts: got go=%0d kill=%0d runs=%0d expected 3 3 3",
               go_cyc.size() - g0, kill_cyc.size() - k0, kill_len.size() - l0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (kill_cyc[k0+i] - go_cyc[g0+i] !== 129 || kill_len[l0+i] !== 4) begin
          n_err++;
          $display("FAIL timeout_kill%0d: got offset=%0d len=%0d expected offset=129 len=4",
                   i, kill_cyc[k0+i] - go_cyc[g0+i], kill_len[l0+i]);
        end
        if (i > 0) begin
          n_vec++;
          if (go_cyc[g0+i] - go_cyc[g0+i-1] !== 135) begin
            n_err++;
            $display("FAIL timeout_go_spacing%0d: got %0d expected 135",
                     i, go_cyc[g0+i] - go_cyc[g0+i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    bit seen; int g0, k0, l0; logic e_ok; logic [2:0] e_tr;
    worker_en = 1'b0;
    g0 = go_cyc.size(); k0 = kill_cyc.size(); l0 = kill_len.size();
    send_req();
    exp_ok.push_back(1'b0); exp_tries.push_back(3'd1);
    for (int i = 0; i < 10 && go !== 1'b1; i++) @(negedge clk);
    repeat (50) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_resp(300, seen);
    e_ok = exp_ok.pop_front(); e_tr = exp_tries.pop_front();
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL abort_resp: no response, expected ok=%b tries=%0d", e_ok, e_tr);
    end else begin
      if (obs_ok[obs_idx] !== e_ok || obs_tries[obs_idx] !== e_tr) begin
        n_err++;
        $display("FAIL abort_resp: got ok=%b tries=%0d expected ok=%b tries=%0d",
                 obs_ok[obs_idx], obs_tries[obs_idx], e_ok, e_tr);
      end
      obs_idx++;
    end
    n_vec++;
    if (go_cyc.size() - g0 !== 1 || kill_cyc.size() - k0 !== 1 || kill_len.size() - l0 !== 1) begin
      n_err++;
      $display("FAIL abort_counts: got go=%0d kill=%0d runs=%0d expected 1 1 1",
               go_cyc.size() - g0, kill_cyc.size() - k0, kill_len.size() - l0);
    end else begin
      n_vec++;
      if (kill_cyc[k0] - go_cyc[g0] !== 51 || kill_len[l0] !== 4) begin
        n_err++;
        $display("FAIL abort_kill: got offset=%0d len=%0d expected offset=51 len=4",
                 kill_cyc[k0] - go_cyc[g0], kill_len[l0]);
      end
    end
  endtask

  task automatic test_reset_mid_kill();
    bit hit_kill = 1'b0;
    worker_en = 1'b0;
    send_req();
    for (int i = 0; i < 300 && !hit_kill; i++) begin
      @(negedge clk);
      if (kill === 1'b1) hit_kill = 1'b1;
    end
    n_vec++;
    if (!hit_kill) begin
      n_err++; $display("FAIL rstkill_reach: kill never seen, expected kill=1");
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (kill !== 1'b0 || req_ready !== 1'b1 || go !== 1'b0) begin
      n_err++;
      $display("FAIL rstkill_drop: got kill=%b ready=%b go=%b expected 0 1 0", kill, req_ready, go);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (kill !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rstkill_no_recover: got kill=%b ready=%b expected 0 1", kill, req_ready);
    end
    test_success(102, "rstkill_new");
  endtask

  task automatic test_hold_stray();
    bit seen = 1'b0; int g0; logic e_ok; logic [2:0] e_tr;
    n_vec++;
    if (err_spurious !== 1'b0) begin
      n_err++; $display("FAIL stray_pre: got err_spurious=%b expected 0", err_spurious);
    end
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err_spurious !== 1'b1 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL stray_flag: got err=%b ready=%b expected 1 1", err_spurious, req_ready);
    end
    worker_en = 1'b1; worker_delay = 102; resp_ready = 1'b0;
    send_req();
    exp_ok.push_back(1'b1); exp_tries.push_back(3'd1);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL hold_reach: resp_valid never seen, expected 1");
    end
    g0 = go_cyc.size();
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({resp_valid, resp_ok, resp_tries, req_ready} !== 6'b1_1_001_0) begin
        n_err++;
        $display("FAIL hold_stable%0d: got valid=%b ok=%b tries=%0d ready=%b expected 1 1 1 0",
                 i, resp_valid, resp_ok, resp_tries, req_ready);
      end
      if (i == 3) begin req_valid = 1'b1; abort = 1'b1; end
      if (i == 4) begin req_valid = 1'b0; abort = 1'b0; end
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_resp(20, seen);
    e_ok = exp_ok.pop_front(); e_tr = exp_tries.pop_front();
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL hold_resp: no response, expected ok=%b tries=%0d", e_ok, e_tr);
    end else begin
      if (obs_ok[obs_idx] !== e_ok || obs_tries[obs_idx] !== e_tr) begin
        n_err++;
        $display("FAIL hold_resp: got ok=%b tries=%0d expected ok=%b tries=%0d",
                 obs_ok[obs_idx], obs_tries[obs_idx], e_ok, e_tr);
      end
      obs_idx++;
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || go_cyc.size() !== g0 || err_spurious !== 1'b1) begin
      n_err++;
      $display("FAIL hold_after: got valid=%b ready=%b new_go=%0d err=%b expected 0 1 0 1",
               resp_valid, req_ready, go_cyc.size() - g0, err_spurious);
    end
  endtask

  task automatic test_exclusive();
    n_vec++;
    if (overlap !== 1'b0) begin
      n_err++; $display("FAIL go_kill_exclusive: got overlap=%b expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_success(102, "success");
    test_timeout();
    test_success(128, "exact_tc");
    test_abort();
    test_reset_mid_kill();
    test_hold_stray();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units, expected completion");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/fsm_supervisor.md
FSM_SUPERVISOR -- requirements
Module: fsm_supervisor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 128, which is the WAIT cycles allowed before kill (legal 2..1023).
REQ-003 The block SHALL have parameter KILL_HOLD, default 4, which is the cycles kill is held high (legal 1..15).
REQ-004 The block SHALL have parameter MAX_RETRY, default 2, which is the relaunches after a timeout (legal 0..6).
REQ-005 The block SHALL have port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit: host requests a job.
REQ-008 The block SHALL have port req_ready, output, 1 bit: supervisor idle and accepting.
REQ-009 The block SHALL have port abort, input, 1 bit: host cancels the current job.
REQ-010 The block SHALL have port go, output, 1 bit: single-cycle start pulse to the worker FSM.
REQ-011 The block SHALL have port kill, output, 1 bit: abort level to the worker FSM.
REQ-012 The block SHALL have port done, input, 1 bit: single-cycle completion pulse from the worker FSM.
REQ-013 The block SHALL have port resp_valid, output, 1 bit: job result available.
REQ-014 The block SHALL have port resp_ready, input, 1 bit: host consumes the result.
REQ-015 The block SHALL have port resp_ok, output, 1 bit: 1 means the job completed; 0 means timed out or aborted.
REQ-016 The block SHALL have port resp_tries, output, 3 bits: number of go pulses issued for this job.
REQ-017 The block SHALL have port err_spurious, output, 1 bit: sticky flag, done seen outside WAIT.

Function
REQ-018 The state machine SHALL have states IDLE, LAUNCH, WAIT, KILL, RECOVER and REPORT.
REQ-019 req_ready SHALL be a combinational decode of state==IDLE; all other outputs SHALL be registered.
REQ-020 In IDLE, req_valid && req_ready SHALL clear tries and move to LAUNCH.
REQ-021 LAUNCH SHALL last one cycle: go=1 in exactly this cycle, tries+1, watchdog cleared, then move to WAIT.
REQ-022 WAIT SHALL increment the watchdog each cycle; done SHALL move to REPORT with resp_ok=1.
REQ-023 In WAIT, abort SHALL set the abort flag and move to KILL.
REQ-024 In WAIT, watchdog==TIMEOUT-1 without done SHALL move to KILL.
REQ-025 Priority in WAIT SHALL be done, then abort, then timeout; done on the same cycle as either other event SHALL count as success.
REQ-026 KILL SHALL hold kill=1 for exactly KILL_HOLD cycles, then move to RECOVER.
REQ-027 RECOVER SHALL hold kill=0 for exactly 2 cycles, the worker's kill-release plus idle settle.
REQ-028 On leaving RECOVER: if the abort flag is set or tries==MAX_RETRY+1, the block SHALL move to REPORT with resp_ok=0; otherwise it SHALL move to LAUNCH.
REQ-029 In REPORT, resp_valid SHALL be 1 and resp_ok and resp_tries SHALL be stable until resp_ready is sampled 1; the block SHALL then move to IDLE with resp_valid=0 next cycle.
REQ-030 abort outside WAIT SHALL be ignored, and req_valid outside IDLE SHALL be ignored (not queued).
REQ-031 done in any state other than WAIT SHALL set err_spurious, and SHALL otherwise be ignored; err_spurious SHALL clear only on reset.
REQ-032 The watchdog SHALL be 10 bits, SHALL be unsigned, and SHALL never wrap, because it is cleared on every entry to WAIT and KILL.
REQ-033 go and kill SHALL never both be 1 in any cycle.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE and clear all counters and flags.
REQ-035 During reset, go, kill, resp_valid, resp_ok, resp_tries and err_spurious SHALL all be 0, and req_ready SHALL be 1.
REQ-036 Reset asserted mid-KILL SHALL drop kill immediately; no RECOVER SHALL follow.
REQ-037 After rst_n rises, a request SHALL be accepted in the first clock edge it is valid.

Structure
REQ-038 Package fsm_supervisor_pkg SHALL hold the state_t enum (3 bits) and the default parameter constants.
REQ-039 One sub-module, sup_timer, SHALL be used: a loadable up-counter with a terminal-count compare, shared for the watchdog, kill hold and recover count.
REQ-040 Target RTL size SHALL be 150-300 lines in total.

Verification
REQ-041 The bench SHALL use a behavioural worker model: done 102 cycles after go, and idle one cycle after kill falls.
REQ-042 Request with a worker done 102 cycles after go -> the bench SHALL see one go, no kill, resp_ok=1, resp_tries=1.
REQ-043 Worker never asserts done -> the bench SHALL see go at launch and 3 go pulses spaced 128+4+2+1 cycles apart, kill 4 cycles after each timeout, resp_ok=0, resp_tries=3.
REQ-044 done on the exact cycle the watchdog reaches 127 -> the bench SHALL see resp_ok=1, resp_tries=1, kill never asserted.
REQ-045 abort 50 cycles into WAIT -> the bench SHALL see kill for 4 cycles, no relaunch, resp_ok=0, resp_tries=1.
REQ-046 rst_n low in the 2nd KILL cycle -> the bench SHALL see kill=0 the same cycle and req_ready=1; a new request after release SHALL complete with resp_ok=1.
REQ-047 resp_ready held low for 10 cycles, plus a stray done in IDLE -> the bench SHALL see resp_valid and its fields stable for 10 cycles, req_ready=0 throughout, and err_spurious=1 afterwards.
